r_inst_loader: RTL and testbench
================================

Name: r_inst_loader

Overview:
- Encoder/writer counterpart to the single-cycle R-type datapath's instruction decode.
- Accepts compact R-type commands (ALU opcode plus rs/rt/rd) over a valid/ready handshake.
- Encodes each command into a 32-bit MIPS R-type word, buffers it in a small FIFO, and writes it sequentially into instruction memory from address 0.
- Used by the bench/boot path to load programs before the CPU is released from reset.

Parameters:
- ADDR_W, 6, instruction-memory word-address width.
- DEPTH, 4, command FIFO depth (power of 2, minimum 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a load session, accepted only in IDLE or DONE.
- len  in  ADDR_W+1  number of words to load; latched on an accepted start.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready at a rising edge.
- alu_op  in  3  ALU opcode of the command.
- rs  in  5  source register A.
- rt  in  5  source register B.
- rd  in  5  destination register.
- mem_busy  in  1  memory cannot take a write this cycle; blocks FIFO pop.
- mem_we  out  1  registered one-cycle write strobe.
- mem_addr  out  ADDR_W  registered write word address.
- mem_wdata  out  32  registered encoded instruction word.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset: state=IDLE; FIFO emptied; write address counter and written count = 0. Outputs in_ready, mem_we, busy, done = 0; mem_addr = 0; mem_wdata = 0. Reset mid-session aborts it; no further writes occur.
- Encoding: word = {6'b000000, rs, rt, rd, 5'b00000, funct}, shamt always 0. funct by alu_op:
  - 100 -> 100000 (add)
  - 101 -> 100010 (sub)
  - 000 -> 100100 (and)
  - 001 -> 100101 (or)
  - 010 -> 100110 (xor)
  - 011 -> 100111 (nor)
  - 110 -> 101011 (sltu)
  - 111 -> 000100 (sllv)
  - Encoding happens at push time; the FIFO stores 32-bit words.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE + start: latch len; clear address, accepted count and written count; go to RUN (done drops the next cycle). If len==0, go directly to DONE instead of RUN.
  - RUN: start is ignored. Go to DONE on the edge after the write with written count == len-1 is issued, so done rises in the same cycle mem_we is high for the last word.
  - DONE: done held high until the next accepted start or rst.
- in_ready = (state==RUN) && !fifo_full && (accepted_count < len). It is combinational from registered state only; there is no combinational path from in_valid.
- Pop: at each edge in RUN with FIFO non-empty, !mem_busy, and written count < len, pop the head. On that pop, the next cycle has mem_we=1, mem_wdata=head, mem_addr=current address; address and written count then increment. mem_we=0 in every cycle without a pop.
- Latency: a command accepted at edge k reaches mem_we=1 in the cycle after edge k+1, given an empty FIFO and mem_busy=0. Sustained throughput is one word per cycle.
- Simultaneous push and pop: allowed, occupancy unchanged. A full FIFO blocks the push even if a pop occurs the same edge (no bypass).
- mem_busy high: the FIFO holds, no write strobe; a full FIFO drops in_ready.
- Address wraps modulo 2^ADDR_W. If len > 2^ADDR_W, later words overwrite low addresses; no error flag.
- Pointers wrap modulo DEPTH; a separate count tracks full/empty.

Test Plan:
- rst, start len=1, command alu_op=100 rs=1 rt=2 rd=3 -> one mem_we at addr 0, wdata 0x00221820; done=1 in the same cycle; busy=0 afterwards.
- len=8, all eight alu_op values streamed back-to-back with mem_busy=0 -> eight consecutive mem_we cycles at addrs 0..7, funct per table (e.g. op 111 -> funct 0x04); in_ready drops after the 8th accept.
- len=6, mem_busy=1 for 10 cycles while pushing -> in_ready low after 4 accepts, no mem_we. Release mem_busy -> 6 writes in order with no loss or duplication.
- start with len=0 -> DONE next cycle, no mem_we, in_ready never high. A start pulse during RUN -> ignored, len unchanged.
- rst asserted after 2 of 5 words are written -> all outputs at reset values next cycle. A new start len=1 -> write at addr 0.
- ADDR_W=2, len=5 -> 5th write at addr 0 (wrap), done asserted with it.

Source files
------------

// File: rtl/r_inst_loader.sv
// rtl/r_inst_loader.sv - R-type command encoder and sequential instruction-memory writer
//
// Accepts compact R-type commands (alu_op, rs, rt, rd), encodes each into a
// 32-bit MIPS R-type word at push time, buffers it in a small FIFO and writes
// the words into instruction memory at consecutive addresses starting from 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins a session (honoured in IDLE or DONE)
//   len        number of words in the session, latched on an accepted start
//   in_valid   command valid
//   in_ready   command accepted when in_valid && in_ready at a rising edge
//   alu_op     ALU opcode of the command
//   rs/rt/rd   source A, source B and destination registers
//   mem_busy   memory cannot take a write this cycle
//   mem_we     registered one-cycle write strobe
//   mem_addr   registered write word address
//   mem_wdata  registered encoded instruction word
//   busy       high while loading
//   done       high once the session has written all its words

module r_inst_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   acc_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W-1:0] addr_q;

    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;

    logic fifo_full;
    logic fifo_empty;
    logic start_acc;
    logic push;
    logic pop;
    logic last_pop;

    function automatic logic [5:0] funct_of(input logic [2:0] op);
        logic [5:0] f;
        case (op)
            3'b100:  f = 6'b100000;
            3'b101:  f = 6'b100010;
            3'b000:  f = 6'b100100;
            3'b001:  f = 6'b100101;
            3'b010:  f = 6'b100110;
            3'b011:  f = 6'b100111;
            3'b110:  f = 6'b101011;
            default: f = 6'b000100;
        endcase
        return f;
    endfunction

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign start_acc  = start && (state != S_RUN);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_RUN) && !fifo_empty && !mem_busy && (wr_cnt < len_q);
    assign last_pop   = pop && (wr_cnt == len_q - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_pop) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; in_ready depends only on registered state, never on in_valid
    always_comb begin
        busy     = (state == S_RUN);
        done     = (state == S_DONE);
        in_ready = (state == S_RUN) && !fifo_full && (acc_cnt < len_q);
    end

    // Datapath: counters, FIFO pointers and the registered memory write port
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            addr_q    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_acc) begin
                len_q    <= len;
                acc_cnt  <= '0;
                wr_cnt   <= '0;
                addr_q   <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    acc_cnt <= acc_cnt + 1'b1;
                end
                if (pop) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= fifo_mem[rd_ptr];
                    rd_ptr    <= rd_ptr + 1'b1;
                    addr_q    <= addr_q + 1'b1;
                    wr_cnt    <= wr_cnt + 1'b1;
                end
                // Push and pop together leave occupancy unchanged
                if (push && !pop) begin
                    fifo_cnt <= fifo_cnt + 1'b1;
                end else if (pop && !push) begin
                    fifo_cnt <= fifo_cnt - 1'b1;
                end
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by fifo_cnt
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {6'b000000, rs, rt, rd, 5'b00000, funct_of(alu_op)};
        end
    end

endmodule

// File: tb/tb_r_inst_loader.sv
// tb/tb_r_inst_loader.sv - directed self-checking bench for r_inst_loader

module tb_r_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_w;
    logic [6:0]  len;
    logic [2:0]  len_w;
    logic        in_valid, in_valid_w;
    logic        in_ready, in_ready_w;
    logic [2:0]  alu_op;
    logic [4:0]  rs, rt, rd;
    logic        mem_busy;
    logic        mem_we, mem_we_w;
    logic [5:0]  mem_addr;
    logic [1:0]  mem_addr_w;
    logic [31:0] mem_wdata, mem_wdata_w;
    logic        busy, busy_w, done, done_w;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    r_inst_loader #(.ADDR_W(6), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .rs(rs), .rt(rt), .rd(rd),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    r_inst_loader #(.ADDR_W(2), .DEPTH(4)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .len(len_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .alu_op(alu_op), .rs(rs), .rt(rt), .rd(rd),
        .mem_busy(mem_busy), .mem_we(mem_we_w), .mem_addr(mem_addr_w),
        .mem_wdata(mem_wdata_w), .busy(busy_w), .done(done_w)
    );

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic [31:0] word;
    } vec_t;

    vec_t vec [8];

    logic [31:0] wq[$];
    logic [5:0]  aq[$];
    logic        dq[$];
    int          cq[$];
    logic [31:0] wq_w[$];
    logic [1:0]  aq_w[$];
    logic        dq_w[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wq.push_back(mem_wdata);
            aq.push_back(mem_addr);
            dq.push_back(done);
            cq.push_back(cyc);
        end
        if (mem_we_w) begin
            wq_w.push_back(mem_wdata_w);
            aq_w.push_back(mem_addr_w);
            dq_w.push_back(done_w);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        wq.delete(); aq.delete(); dq.delete(); cq.delete();
        wq_w.delete(); aq_w.delete(); dq_w.delete();
    endtask

    task automatic do_start(input bit w, input int l);
        if (w) begin start_w = 1'b1; len_w = 3'(l); end
        else   begin start   = 1'b1; len   = 7'(l); end
        step();
        start = 1'b0;
        start_w = 1'b0;
    endtask

    task automatic push(input bit w, input int i);
        int n;
        alu_op = vec[i].op; rs = vec[i].a; rt = vec[i].b; rd = vec[i].c;
        if (w) in_valid_w = 1'b1; else in_valid = 1'b1;
        n = 0;
        while (!(w ? in_ready_w : in_ready) && n < 100) begin
            step();
            n++;
        end
        chk("push_accept_timeout", 32'(n >= 100), 32'd0);
        step();
        in_valid = 1'b0;
        in_valid_w = 1'b0;
    endtask

    task automatic wait_done(input bit w);
        int n;
        n = 0;
        while (!(w ? done_w : done) && n < 200) begin
            step();
            n++;
        end
        chk("done_timeout", 32'(n >= 200), 32'd0);
    endtask

    initial begin
        vec[0] = '{3'b100, 5'd1,  5'd2,  5'd3,  32'h0022_1820};
        vec[1] = '{3'b101, 5'd4,  5'd5,  5'd6,  32'h0085_3022};
        vec[2] = '{3'b000, 5'd7,  5'd8,  5'd9,  32'h00E8_4824};
        vec[3] = '{3'b001, 5'd10, 5'd11, 5'd12, 32'h014B_6025};
        vec[4] = '{3'b010, 5'd13, 5'd14, 5'd15, 32'h01AE_7826};
        vec[5] = '{3'b011, 5'd16, 5'd17, 5'd18, 32'h0211_9027};
        vec[6] = '{3'b110, 5'd31, 5'd0,  5'd31, 32'h03E0_F82B};
        vec[7] = '{3'b111, 5'd0,  5'd31, 5'd1,  32'h001F_0804};

        rst = 1'b1; start = 1'b0; start_w = 1'b0; len = '0; len_w = '0;
        in_valid = 1'b0; in_valid_w = 1'b0; alu_op = '0; rs = '0; rt = '0; rd = '0;
        mem_busy = 1'b0;
        step(); step();

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        step();

        // Single word session
        clr();
        do_start(0, 1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        push(0, 0);
        wait_done(0);
        chk("single_count", wq.size(), 32'd1);
        if (wq.size() == 1) begin
            chk("single_addr", {26'd0, aq[0]}, 32'd0);
            chk("single_wdata", wq[0], 32'h0022_1820);
            chk("single_done_with_we", {31'd0, dq[0]}, 32'd1);
        end
        step();
        chk("single_busy_after", {31'd0, busy}, 32'd0);
        chk("single_done_held", {31'd0, done}, 32'd1);

        // All eight opcodes back-to-back
        clr();
        do_start(0, 8);
        for (int i = 0; i < 8; i++) push(0, i);
        chk("stream_in_ready_after_8", {31'd0, in_ready}, 32'd0);
        wait_done(0);
        chk("stream_count", wq.size(), 32'd8);
        if (wq.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("stream_wdata_%0d", i), wq[i], vec[i].word);
                chk($sformatf("stream_addr_%0d", i), {26'd0, aq[i]}, 32'(i));
                chk($sformatf("stream_cycle_%0d", i), 32'(cq[i] - cq[0]), 32'(i));
            end
            chk("stream_done_with_last", {31'd0, dq[7]}, 32'd1);
            chk("stream_done_before_last", {31'd0, dq[6]}, 32'd0);
        end

        // Memory busy back-pressure
        clr();
        mem_busy = 1'b1;
        do_start(0, 6);
        for (int i = 0; i < 4; i++) push(0, i);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("bp_no_write", wq.size(), 32'd0);
        chk("bp_still_busy", {31'd0, busy}, 32'd1);
        mem_busy = 1'b0;
        push(0, 4);
        push(0, 5);
        wait_done(0);
        chk("bp_count", wq.size(), 32'd6);
        if (wq.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("bp_wdata_%0d", i), wq[i], vec[i].word);
                chk($sformatf("bp_addr_%0d", i), {26'd0, aq[i]}, 32'(i));
            end
        end

        // Zero-length session
        clr();
        do_start(0, 0);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("len0_no_write", wq.size(), 32'd0);

        // Start during RUN is ignored
        clr();
        do_start(0, 2);
        push(0, 0);
        do_start(0, 5);
        push(0, 1);
        chk("run_start_in_ready", {31'd0, in_ready}, 32'd0);
        wait_done(0);
        chk("run_start_count", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("run_start_addr1", {26'd0, aq[1]}, 32'd1);
            chk("run_start_wdata1", wq[1], vec[1].word);
        end

        // Reset mid-session
        clr();
        do_start(0, 5);
        push(0, 0);
        push(0, 1);
        for (int n = 0; n < 20 && wq.size() < 2; n++) step();
        chk("abort_two_written", wq.size(), 32'd2);
        rst = 1'b1;
        step();
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abort_no_more_writes", wq.size(), 32'd2);
        clr();
        do_start(0, 1);
        push(0, 2);
        wait_done(0);
        chk("restart_count", wq.size(), 32'd1);
        if (wq.size() == 1) begin
            chk("restart_addr", {26'd0, aq[0]}, 32'd0);
            chk("restart_wdata", wq[0], vec[2].word);
        end

        // Address wrap with ADDR_W=2
        clr();
        do_start(1, 5);
        for (int i = 0; i < 5; i++) push(1, i);
        wait_done(1);
        chk("wrap_count", wq_w.size(), 32'd5);
        if (wq_w.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("wrap_addr_%0d", i), {30'd0, aq_w[i]}, 32'(i % 4));
                chk($sformatf("wrap_wdata_%0d", i), wq_w[i], vec[i].word);
            end
            chk("wrap_done_with_last", {31'd0, dq_w[4]}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
